// File: rtl/riscalar_pkg.sv
`default_nettype none
// ============================================================================
// Package     : riscalar_pkg
// Description : Shared types and constants for the riscalar front end.
//               XLEN            - architectural word width
//               INST_NOP        - canonical NOP encoding (addi x0,x0,0)
//               fetch_entry_t   - one fetched instruction with its PC
//               word_align()    - clears the byte-offset bits of an address
// Revision    : 1.0 - initial release
// ============================================================================
package riscalar_pkg;

    localparam int unsigned     XLEN     = 32;
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage : riscalar_pkg
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : In-order synchronous FIFO of fetch_entry_t between the imem
//               response path and decode. Head is read straight out of the
//               storage flops, so a pushed entry is visible the cycle after
//               the push. Flush empties the queue and wins over push/pop.
// Ports       : clk          - clock
//               rst          - asynchronous active-high reset
//               i_flush      - discard all entries
//               i_push       - write i_push_data at the tail
//               i_push_data  - entry to write
//               i_pop        - retire the head entry
//               o_head_valid - queue holds at least one entry
//               o_head       - head entry (zero when empty)
//               o_count      - current occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import riscalar_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  fetch_entry_t               i_push_data,
    input  logic                       i_pop,
    output logic                       o_head_valid,
    output fetch_entry_t               o_head,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned       c_PW        = $clog2(DEPTH);
    localparam int unsigned       c_CW        = c_PW + 1;
    localparam logic [c_PW-1:0]   c_PTR_ONE   = c_PW'(1);
    localparam logic [c_CW-1:0]   c_CNT_ONE   = c_CW'(1);
    localparam logic [c_CW-1:0]   c_CNT_FULL  = c_CW'(DEPTH);

    fetch_entry_t      r_mem [DEPTH];
    logic [c_PW-1:0]   r_rd_ptr;
    logic [c_PW-1:0]   r_wr_ptr;
    logic [c_CW-1:0]   r_count;

    logic              w_empty;
    logic              w_full;
    logic              w_push_eff;
    logic              w_pop_eff;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_CNT_FULL);
    // Credits upstream make a push into a full queue impossible; the guard
    // only keeps the pointers coherent if that contract is ever broken.
    assign w_push_eff = i_push && !i_flush && !w_full;
    assign w_pop_eff  = i_pop  && !i_flush && !w_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_eff) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop_eff) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            unique case ({w_push_eff, w_pop_eff})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: its contents are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (w_push_eff) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head_valid = !w_empty;
    assign o_head       = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count      = r_count;

endmodule : fetch_queue
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage feeding decode. Issues sequential
//               word fetches over a valid/ready request channel, buffers the
//               in-order responses in fetch_queue and presents them to decode
//               via valid/ready. A redirect from execute flushes the queue,
//               arms a kill counter for every response still in flight and
//               restarts fetch at the new PC.
// Config      : FETCH_PERF_EN - when defined, builds 32-bit wrapping counters
//               of delivered instructions and discarded responses; otherwise
//               both counter ports are tied to zero.
// Ports       : clk_in, rst_in (async, active-high)
//               imem_req_valid_out/ready_in/addr_out  - fetch request channel
//               imem_resp_valid_in/data_in            - in-order responses
//               redirect_valid_in/pc_in               - new PC from execute
//               inst_valid_out/ready_in, inst_out, pc_out - decode handshake
//               fetch_count_out, kill_count_out       - perf counters
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import riscalar_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned     QUEUE_DEPTH     = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2
) (
    input  logic            clk_in,
    input  logic            rst_in,
    output logic            imem_req_valid_out,
    input  logic            imem_req_ready_in,
    output logic [XLEN-1:0] imem_req_addr_out,
    input  logic            imem_resp_valid_in,
    input  logic [XLEN-1:0] imem_resp_data_in,
    input  logic            redirect_valid_in,
    input  logic [XLEN-1:0] redirect_pc_in,
    output logic            inst_valid_out,
    input  logic            inst_ready_in,
    output logic [XLEN-1:0] inst_out,
    output logic [XLEN-1:0] pc_out,
    output logic [31:0]     fetch_count_out,
    output logic [31:0]     kill_count_out
);

    localparam int unsigned     c_OW      = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned     c_CW      = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [c_OW-1:0] c_OUT_ONE = c_OW'(1);

    logic                r_started;
    logic [XLEN-1:0]     r_fetch_pc;
    logic [XLEN-1:0]     r_resp_pc;
    logic [c_OW-1:0]     r_outstanding;
    logic [c_OW-1:0]     r_kill_cnt;

    logic [c_OW-1:0]     w_outstanding_nxt;
    logic [c_CW-1:0]     w_q_count;
    logic                w_credit_ok;
    logic                w_fire;
    logic                w_resp_ok;
    logic                w_kill_hit;
    logic                w_push;
    logic                w_pop;
    logic [XLEN-1:0]     w_redirect_pc;
    fetch_entry_t        w_push_entry;
    fetch_entry_t        w_head;

    // ------------------------------------------------------------------
    // Request channel. Every accepted request reserves a queue slot, so the
    // sum of in-flight requests and buffered entries never exceeds the depth.
    // The request is held back for the first cycle after reset release.
    // ------------------------------------------------------------------
    assign w_credit_ok = (32'(r_outstanding) < MAX_OUTSTANDING) &&
                         ((32'(r_outstanding) + 32'(w_q_count)) < QUEUE_DEPTH);

    assign imem_req_valid_out = r_started && !redirect_valid_in && w_credit_ok;
    assign imem_req_addr_out  = r_fetch_pc;
    assign w_fire             = imem_req_valid_out && imem_req_ready_in;

    // A response with nothing outstanding is ignored entirely.
    assign w_resp_ok  = imem_resp_valid_in && (r_outstanding != '0);
    assign w_kill_hit = w_resp_ok && (r_kill_cnt != '0);
    assign w_push     = w_resp_ok && !redirect_valid_in && !w_kill_hit;
    assign w_pop      = inst_valid_out && inst_ready_in;

    assign w_redirect_pc = word_align(redirect_pc_in);

    always_comb begin
        w_outstanding_nxt = r_outstanding;
        unique case ({w_fire, w_resp_ok})
            2'b10:   w_outstanding_nxt = r_outstanding + c_OUT_ONE;
            2'b01:   w_outstanding_nxt = r_outstanding - c_OUT_ONE;
            default: w_outstanding_nxt = r_outstanding;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_started     <= 1'b0;
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_kill_cnt    <= '0;
        end else begin
            r_started     <= 1'b1;
            r_outstanding <= w_outstanding_nxt;
            if (redirect_valid_in) begin
                // No request fires during a redirect, so the next outstanding
                // count is exactly the set of responses that are now stale.
                r_fetch_pc <= w_redirect_pc;
                r_resp_pc  <= w_redirect_pc;
                r_kill_cnt <= w_outstanding_nxt;
            end else begin
                if (w_fire) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_kill_hit) begin
                    r_kill_cnt <= r_kill_cnt - c_OUT_ONE;
                end else if (w_resp_ok) begin
                    r_resp_pc <= r_resp_pc + 32'd4;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Instruction queue
    // ------------------------------------------------------------------
    assign w_push_entry.pc   = r_resp_pc;
    assign w_push_entry.inst = imem_resp_data_in;

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fetch_queue (
        .clk          (clk_in),
        .rst          (rst_in),
        .i_flush      (redirect_valid_in),
        .i_push       (w_push),
        .i_push_data  (w_push_entry),
        .i_pop        (w_pop),
        .o_head_valid (inst_valid_out),
        .o_head       (w_head),
        .o_count      (w_q_count)
    );

    assign inst_out = w_head.inst;
    assign pc_out   = w_head.pc;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef FETCH_PERF_EN
    logic        w_discard;
    logic [31:0] r_fetch_count;
    logic [31:0] r_kill_count;

    assign w_discard = w_resp_ok && (redirect_valid_in || w_kill_hit);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_fetch_count <= '0;
            r_kill_count  <= '0;
        end else begin
            if (w_pop) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (w_discard) begin
                r_kill_count <= r_kill_count + 32'd1;
            end
        end
    end

    assign fetch_count_out = r_fetch_count;
    assign kill_count_out  = r_kill_count;
`else
    assign fetch_count_out = '0;
    assign kill_count_out  = '0;
`endif

    // imem must never answer a request that was not issued.
    a_resp_has_request : assert property (
        @(posedge clk_in) disable iff (rst_in)
        imem_resp_valid_in |-> (r_outstanding != '0)
    );

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. An imem model answers
//               accepted requests in order with random latency (>= 1 cycle)
//               and an address-derived instruction word. The reference view
//               is architectural: fetch addresses and delivered PCs run
//               sequentially from the last redirect target, every delivered
//               word must match the imem content at its PC, and credit limits
//               are derived from the bench's own in-flight/buffered counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam int unsigned c_QD  = 4;
    localparam int unsigned c_MO  = 2;
    localparam logic [31:0] c_RPC = 32'h0000_0000;
`ifdef FETCH_PERF_EN
    localparam bit c_PERF = 1'b1;
`else
    localparam bit c_PERF = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        imem_req_valid_out;
    logic        imem_req_ready_in = 1'b0;
    logic [31:0] imem_req_addr_out;
    logic        imem_resp_valid_in = 1'b0;
    logic [31:0] imem_resp_data_in = '0;
    logic        redirect_valid_in = 1'b0;
    logic [31:0] redirect_pc_in = '0;
    logic        inst_valid_out;
    logic        inst_ready_in = 1'b0;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic [31:0] fetch_count_out;
    logic [31:0] kill_count_out;

    fetch_unit #(
        .RESET_PC        (c_RPC),
        .QUEUE_DEPTH     (c_QD),
        .MAX_OUTSTANDING (c_MO)
    ) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .imem_req_valid_out (imem_req_valid_out),
        .imem_req_ready_in  (imem_req_ready_in),
        .imem_req_addr_out  (imem_req_addr_out),
        .imem_resp_valid_in (imem_resp_valid_in),
        .imem_resp_data_in  (imem_resp_data_in),
        .redirect_valid_in  (redirect_valid_in),
        .redirect_pc_in     (redirect_pc_in),
        .inst_valid_out     (inst_valid_out),
        .inst_ready_in      (inst_ready_in),
        .inst_out           (inst_out),
        .pc_out             (pc_out),
        .fetch_count_out    (fetch_count_out),
        .kill_count_out     (kill_count_out)
    );

    always #5 clk_in = ~clk_in;

    // Bookkeeping
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Requests accepted by imem but not yet answered
    logic [31:0] pend_addr  [$];
    int          pend_cyc   [$];
    bit          pend_stale [$];

    int          cyc;
    int          occ;
    int          first_valid_cyc;
    logic [31:0] exp_req_addr;
    logic [31:0] exp_pc;
    logic [31:0] exp_fetch;
    logic [31:0] exp_kill;
    bit          hold;
    logic [31:0] hold_addr;

    // Stimulus knobs applied by each cycle
    bit          drv_req_ready;
    bit          drv_inst_ready;
    bit          drv_resp_en;
    bit          drv_redirect;
    logic [31:0] drv_redirect_pc;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_in             = 1'b1;
        imem_req_ready_in  = 1'b0;
        imem_resp_valid_in = 1'b0;
        imem_resp_data_in  = '0;
        redirect_valid_in  = 1'b0;
        redirect_pc_in     = '0;
        inst_ready_in      = 1'b0;
        drv_req_ready = 0; drv_inst_ready = 0; drv_resp_en = 0; drv_redirect = 0;
        drv_redirect_pc = '0;
        #1;
        check("rst_req_valid",  32'(imem_req_valid_out), 32'h0);
        check("rst_req_addr",   imem_req_addr_out,       c_RPC);
        check("rst_inst_valid", 32'(inst_valid_out),     32'h0);
        check("rst_inst",       inst_out,                32'h0);
        check("rst_pc",         pc_out,                  32'h0);
        check("rst_fetch_cnt",  fetch_count_out,         32'h0);
        check("rst_kill_cnt",   kill_count_out,          32'h0);
        repeat (2) @(posedge clk_in);
        pend_addr.delete(); pend_cyc.delete(); pend_stale.delete();
        cyc = 0; occ = 0; first_valid_cyc = -1; hold = 0; hold_addr = '0;
        exp_req_addr = c_RPC; exp_pc = c_RPC; exp_fetch = '0; exp_kill = '0;
    endtask

    // One clock cycle: drive just after the edge, sample mid-cycle and
    // predict what the following edge does.
    task automatic cycle();
        bit resp;
        bit fire;
        bit pop;
        bit exp_v;
        @(posedge clk_in);
        #1;
        rst_in            = 1'b0;
        imem_req_ready_in = drv_req_ready;
        inst_ready_in     = drv_inst_ready;
        redirect_valid_in = drv_redirect;
        redirect_pc_in    = drv_redirect_pc;
        resp = 1'b0;
        if (drv_resp_en && pend_addr.size() > 0) begin
            if (cyc > pend_cyc[0]) resp = 1'b1;
        end
        imem_resp_valid_in = resp;
        imem_resp_data_in  = resp ? imem_word(pend_addr[0]) : $urandom;
        #4;

        if (redirect_valid_in) begin
            foreach (pend_stale[i]) pend_stale[i] = 1'b1;
        end

        exp_v = (cyc >= 1) && !redirect_valid_in &&
                (pend_addr.size() < c_MO) && ((pend_addr.size() + occ) < c_QD);
        check("req_valid", 32'(imem_req_valid_out), 32'(exp_v));
        if (imem_req_valid_out) check("req_addr", imem_req_addr_out, exp_req_addr);
        if (hold && !redirect_valid_in) check("req_hold_addr", imem_req_addr_out, hold_addr);
        check("inst_valid", 32'(inst_valid_out), 32'(occ != 0));
        check("fetch_count", fetch_count_out, c_PERF ? exp_fetch : 32'h0);
        check("kill_count",  kill_count_out,  c_PERF ? exp_kill  : 32'h0);

        fire = imem_req_valid_out && imem_req_ready_in;
        pop  = inst_valid_out && inst_ready_in;

        if (inst_valid_out && first_valid_cyc < 0) first_valid_cyc = cyc;

        if (pop) begin
            check("pop_pc",   pc_out,   exp_pc);
            check("pop_inst", inst_out, imem_word(exp_pc));
            exp_pc    = exp_pc + 32'd4;
            exp_fetch = exp_fetch + 32'd1;
            if (occ > 0) occ--;
        end

        if (resp) begin
            if (pend_stale[0]) exp_kill = exp_kill + 32'd1;
            else               occ++;
            void'(pend_addr.pop_front());
            void'(pend_cyc.pop_front());
            void'(pend_stale.pop_front());
        end

        if (fire) begin
            pend_addr.push_back(exp_req_addr);
            pend_cyc.push_back(cyc);
            pend_stale.push_back(1'b0);
            exp_req_addr = exp_req_addr + 32'd4;
        end

        hold      = imem_req_valid_out && !imem_req_ready_in;
        hold_addr = imem_req_addr_out;

        if (redirect_valid_in) begin
            exp_pc       = {redirect_pc_in[31:2], 2'b00};
            exp_req_addr = {redirect_pc_in[31:2], 2'b00};
            occ          = 0;
        end
        cyc++;
    endtask

    // Advance until decode sees an instruction (bounded) and check its PC.
    task automatic wait_deliver(input string tag, input logic [31:0] want_pc);
        bit seen;
        seen = inst_valid_out;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            seen = inst_valid_out;
        end
        check({tag, "_seen"}, 32'(seen), 32'h1);
        check(tag, pc_out, want_pc);
    endtask

    initial begin
        #2;
        do_reset();

        // 1: streaming with 1-cycle imem
        drv_req_ready = 1; drv_inst_ready = 1; drv_resp_en = 1;
        repeat (12) cycle();
        check("first_valid_cycle", 32'(first_valid_cyc), 32'd3);

        // 2: decode stalls, credits cap requests, then drain in order
        drv_inst_ready = 0;
        repeat (14) cycle();
        drv_inst_ready = 1;
        repeat (10) cycle();

        // 3: two requests in flight, redirect to 0x100
        drv_resp_en = 0;
        repeat (4) cycle();
        drv_redirect = 1; drv_redirect_pc = 32'h0000_0100;
        cycle();
        drv_redirect = 0; drv_resp_en = 1;
        cycle();
        wait_deliver("redir_100_pc", 32'h0000_0100);
        repeat (4) cycle();

        // 4: misaligned redirect target is word-aligned
        drv_redirect = 1; drv_redirect_pc = 32'h0000_0203;
        cycle();
        drv_redirect = 0;
        cycle();
        check("redir_align_addr", imem_req_addr_out, 32'h0000_0200);
        wait_deliver("redir_203_pc", 32'h0000_0200);
        repeat (4) cycle();

        // 5: back-to-back redirects, last one wins
        drv_redirect = 1; drv_redirect_pc = 32'h0000_0040;
        cycle();
        drv_redirect_pc = 32'h0000_0080;
        cycle();
        drv_redirect = 0;
        cycle();
        wait_deliver("redir_b2b_pc", 32'h0000_0080);
        repeat (4) cycle();

        // 6: imem stalls with fetch_pc at the top of memory, then wraps
        drv_req_ready = 0;
        drv_redirect = 1; drv_redirect_pc = 32'hFFFF_FFFC;
        cycle();
        drv_redirect = 0;
        repeat (5) cycle();
        check("wrap_hold_valid", 32'(imem_req_valid_out), 32'h1);
        check("wrap_hold_addr",  imem_req_addr_out,       32'hFFFF_FFFC);
        drv_req_ready = 1;
        cycle();
        cycle();
        check("wrap_addr", imem_req_addr_out, 32'h0000_0000);
        wait_deliver("wrap_pc_top", 32'hFFFF_FFFC);
        cycle();
        wait_deliver("wrap_pc_zero", 32'h0000_0000);

        // Randomized traffic with a mid-run asynchronous reset
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                do_reset();
            end
            drv_req_ready   = ($urandom_range(0, 9) < 7);
            drv_inst_ready  = ($urandom_range(0, 9) < 6);
            drv_resp_en     = ($urandom_range(0, 9) < 6);
            drv_redirect    = ($urandom_range(0, 24) == 0);
            drv_redirect_pc = $urandom;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire
